// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
//   tx_state_e  : transmit FSM states
//   DATA_OFS    : byte offset of the DATA register from the base address
//   STATUS_OFS  : byte offset of the STATUS register from the base address
//   STAT_*      : bit positions inside the STATUS word
//   status_word : packs the status flags into the 32-bit read value
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [31:0] DATA_OFS   = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int unsigned STAT_FULL  = 0;
  localparam int unsigned STAT_EMPTY = 1;
  localparam int unsigned STAT_IDLE  = 2;
  localparam int unsigned STAT_OVF   = 3;

  // Upper bits of the status word read as zero.
  function automatic logic [31:0] status_word(input logic ovf, input logic idle,
                                              input logic empty, input logic full);
    logic [31:0] w;
    w             = '0;
    w[STAT_OVF]   = ovf;
    w[STAT_IDLE]  = idle;
    w[STAT_EMPTY] = empty;
    w[STAT_FULL]  = full;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Data-memory style bus between the address-mapping proxy and a peripheral.
//   addr         : byte address
//   din          : write data
//   write_enable : per-byte write strobes, lane 0 = bit 0
//   dout         : read data, one cycle after the address
interface uart_tx_mmio_if;

  logic [31:0] addr;
  logic [31:0] din;
  logic [3:0]  write_enable;
  logic [31:0] dout;

  modport master (output addr, output din, output write_enable, input dout);
  modport slave  (input addr, input din, input write_enable, output dout);

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO, depth 2**AW, no fall-through: a push becomes visible to
// the read side on the following cycle.
//   clk, rstn : clock and synchronous active-low reset (empties the FIFO)
//   push      : write wdata if not full (ignored when full)
//   pop       : advance the read pointer if not empty (ignored when empty)
//   rdata_c   : head-of-queue data
//   full_c    : all entries occupied
//   empty_c   : no entries
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             push_ok_c;
  logic             pop_ok_c;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty_c   = (wptr == rptr);
  assign full_c    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push_ok_c = push && !full_c;
  assign pop_ok_c  = pop && !empty_c;
  assign rdata_c   = mem[rptr[AW-1:0]];

  // Pointer update; push and pop in one cycle both take effect.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok_c) wptr <= wptr + (AW+1)'(1);
      if (pop_ok_c)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter.
// Byte writes to DATA are queued in a FIFO and shifted out LSB first on txd.
// STATUS reads return {overflow, idle, empty, full} with BRAM-like latency;
// any write to STATUS clears the sticky overflow flag.
//   clk, rstn : clock and synchronous active-low reset
//   bus       : slave side of the data-memory bus (addr/din/write_enable/dout)
//   txd       : serial output, idle high, registered
//   tx_busy   : FIFO non-empty or frame in flight (combinational)
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h10000,
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned FIFO_AW     = 4
) (
  input  logic            clk,
  input  logic            rstn,
  uart_tx_mmio_if.slave   bus,
  output logic            txd,
  output logic            tx_busy
);

  localparam int unsigned CNT_W     = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_PER_BIT - 1);

  tx_state_e        state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             overflow;

  logic             data_sel_c;
  logic             stat_sel_c;
  logic             push_c;
  logic             drop_c;
  logic             stat_wr_c;
  logic             pop_c;
  logic             baud_term_c;
  logic             fifo_full_c;
  logic             fifo_empty_c;
  logic [7:0]       fifo_rdata_c;
  logic             unused_din_c;

  // Address decode and write qualification.
  assign data_sel_c   = (bus.addr == BASE_ADDR + DATA_OFS);
  assign stat_sel_c   = (bus.addr == BASE_ADDR + STATUS_OFS);
  assign push_c       = data_sel_c && bus.write_enable[0];
  assign drop_c       = push_c && fifo_full_c;
  assign stat_wr_c    = stat_sel_c && (|bus.write_enable);
  assign unused_din_c = ^bus.din[31:8];

  assign baud_term_c  = (baud_cnt == BAUD_LAST);
  assign tx_busy      = !fifo_empty_c || (state != IDLE);

  // A byte is taken from the FIFO when idle, or at the end of a stop bit so
  // that consecutive frames run without an idle gap.
  assign pop_c = !fifo_empty_c &&
                 ((state == IDLE) || ((state == STOP) && baud_term_c));

  sync_fifo #(
    .WIDTH (8),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push    (push_c),
    .wdata   (bus.din[7:0]),
    .pop     (pop_c),
    .rdata_c (fifo_rdata_c),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  // Sticky overflow; a dropped push beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rstn)          overflow <= 1'b0;
    else if (drop_c)    overflow <= 1'b1;
    else if (stat_wr_c) overflow <= 1'b0;
  end

  // Read data register: status word for STATUS, zero for everything else.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bus.dout <= '0;
    end else if (stat_sel_c) begin
      bus.dout <= status_word(overflow, state == IDLE, fifo_empty_c, fifo_full_c);
    end else begin
      bus.dout <= '0;
    end
  end

  // Transmit FSM; txd is registered from the current state, so the line lags
  // each state change by one cycle while every bit keeps its full length.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
    end else begin
      case (state)
        START:   txd <= 1'b0;
        DATA:    txd <= shift[0];
        default: txd <= 1'b1;
      endcase

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!fifo_empty_c) begin
            shift <= fifo_rdata_c;
            state <= START;
          end
        end
        START: begin
          if (baud_term_c) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (baud_term_c) begin
            baud_cnt <= '0;
            shift    <= {1'b0, shift[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (baud_term_c) begin
            baud_cnt <= '0;
            if (!fifo_empty_c) begin
              shift <= fifo_rdata_c;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed testbench for uart_tx_mmio. Two instances: a fast one
// (CLK_PER_BIT=4) for serial timing and a slow one (CLK_PER_BIT=65535) whose
// FIFO never drains during the run. Inputs change and outputs are sampled on
// the falling edge.
module tb_uart_tx_mmio;

  localparam logic [31:0] BASE   = 32'h10000;
  localparam logic [31:0] DATA_A = BASE;
  localparam logic [31:0] STAT_A = BASE + 32'd4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic txd_s, busy_s, txd_b, busy_b;

  int passed = 0;
  int total  = 0;

  uart_tx_mmio_if bus_s ();
  uart_tx_mmio_if bus_b ();

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_PER_BIT(4), .FIFO_AW(4)) dut_s (
    .clk(clk), .rstn(rstn), .bus(bus_s), .txd(txd_s), .tx_busy(busy_s));

  uart_tx_mmio #(.BASE_ADDR(BASE), .CLK_PER_BIT(65535), .FIFO_AW(4)) dut_b (
    .clk(clk), .rstn(rstn), .bus(bus_b), .txd(txd_b), .tx_busy(busy_b));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One bus write, sampled at the next rising edge; returns one cycle later.
  task automatic wr(input bit big, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] we);
    if (big) begin
      bus_b.addr = a; bus_b.din = d; bus_b.write_enable = we;
    end else begin
      bus_s.addr = a; bus_s.din = d; bus_s.write_enable = we;
    end
    @(negedge clk);
    bus_b.write_enable = 4'h0; bus_b.addr = 32'h0;
    bus_s.write_enable = 4'h0; bus_s.addr = 32'h0;
  endtask

  // Read with one-cycle latency.
  task automatic rd(input bit big, input logic [31:0] a, output logic [31:0] v);
    if (big) bus_b.addr = a; else bus_s.addr = a;
    @(negedge clk);
    v = big ? bus_b.dout : bus_s.dout;
    bus_b.addr = 32'h0; bus_s.addr = 32'h0;
  endtask

  // Checks one 40-cycle frame on the fast instance, called at its first
  // start-bit sample. Optionally issues a DATA write at sample offset wr_ofs.
  task automatic frame(input logic [7:0] b, input string nm, input int wr_ofs,
                       input logic [7:0] wr_b, output logic busy38, output logic busy39);
    logic expb;
    logic gotb;
    bit   bad;
    int   idx;
    busy38 = 1'bx;
    busy39 = 1'bx;
    for (int k = 0; k < 10; k++) begin
      expb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      bad  = 1'b0;
      gotb = expb;
      for (int j = 0; j < 4; j++) begin
        idx = k * 4 + j;
        if (txd_s !== expb) begin bad = 1'b1; gotb = txd_s; end
        if (idx == 38) busy38 = busy_s;
        if (idx == 39) busy39 = busy_s;
        if (idx == wr_ofs) begin
          bus_s.addr = DATA_A; bus_s.din = {24'h0, wr_b}; bus_s.write_enable = 4'h1;
        end else if (idx == wr_ofs + 1) begin
          bus_s.write_enable = 4'h0; bus_s.addr = 32'h0;
        end
        @(negedge clk);
      end
      total++;
      if (bad) $display("FAIL %s bit%0d txd got %b want %b", nm, k, gotb, expb);
      else passed++;
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (txd_s !== 1'b1) $display("FAIL reset_txd got %b want 1", txd_s); else passed++;
    total++; if (busy_s !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_s); else passed++;
    total++; if (bus_s.dout !== 32'h0) $display("FAIL reset_dout got %h want 0", bus_s.dout); else passed++;
    total++; if (txd_b !== 1'b1) $display("FAIL reset_txd_b got %b want 1", txd_b); else passed++;
    total++; if (busy_b !== 1'b0) $display("FAIL reset_busy_b got %b want 0", busy_b); else passed++;
    rstn = 1'b1;
    rd(1'b0, STAT_A, v);
    total++; if (v !== 32'h6) $display("FAIL reset_status got %h want 6", v); else passed++;
    rd(1'b1, STAT_A, v);
    total++; if (v !== 32'h6) $display("FAIL reset_status_b got %h want 6", v); else passed++;
  endtask

  // Single 0x55: start bit on txd two cycles after the push; busy falls
  // 40 cycles after the pop cycle.
  task automatic test_single();
    logic b38, b39;
    wr(1'b0, DATA_A, 32'hFFFF_FF55, 4'h1);
    total++; if (busy_s !== 1'b1) $display("FAIL single_busy_push got %b want 1", busy_s); else passed++;
    @(negedge clk);
    total++; if (txd_s !== 1'b1) $display("FAIL single_pop_cycle_txd got %b want 1", txd_s); else passed++;
    @(negedge clk);
    frame(8'h55, "single_55", -1, 8'h00, b38, b39);
    total++; if (b38 !== 1'b1) $display("FAIL single_busy_last got %b want 1", b38); else passed++;
    total++; if (b39 !== 1'b0) $display("FAIL single_busy_drop got %b want 0", b39); else passed++;
  endtask

  // Slow instance: the first byte goes straight to the shift register, so it
  // takes 17 writes to fill the 16-entry FIFO and the 18th overflows.
  task automatic test_overflow();
    logic [31:0] v;
    wr(1'b1, DATA_A, 32'h0000_00AA, 4'b1110);
    rd(1'b1, STAT_A, v);
    total++; if (v !== 32'h6) $display("FAIL ignored_write_status got %h want 6", v); else passed++;
    for (int i = 0; i < 17; i++) wr(1'b1, DATA_A, 32'(i), 4'h1);
    rd(1'b1, STAT_A, v);
    total++; if (v !== 32'h1) $display("FAIL fill_status got %h want 1", v); else passed++;
    wr(1'b1, DATA_A, 32'h0000_00EE, 4'h1);
    rd(1'b1, STAT_A, v);
    total++; if (v[3] !== 1'b1) $display("FAIL ovf_bit got %b want 1", v[3]); else passed++;
    total++; if (v[0] !== 1'b1) $display("FAIL ovf_full_bit got %b want 1", v[0]); else passed++;
    total++; if (v !== 32'h9) $display("FAIL ovf_status got %h want 9", v); else passed++;
    wr(1'b1, STAT_A, 32'h0, 4'b0100);
    rd(1'b1, STAT_A, v);
    total++; if (v !== 32'h1) $display("FAIL ovf_clear got %h want 1", v); else passed++;
    rd(1'b1, DATA_A, v);
    total++; if (v !== 32'h0) $display("FAIL data_read got %h want 0", v); else passed++;
  endtask

  // 0xA3 then 0x0F in consecutive cycles (second push coincides with first pop).
  task automatic test_back_to_back();
    logic b38, b39;
    wr(1'b0, DATA_A, 32'h0000_00A3, 4'h1);
    wr(1'b0, DATA_A, 32'h0000_000F, 4'h1);
    total++; if (txd_s !== 1'b1) $display("FAIL b2b_pop_cycle_txd got %b want 1", txd_s); else passed++;
    @(negedge clk);
    frame(8'hA3, "b2b_A3", -1, 8'h00, b38, b39);
    total++; if (b39 !== 1'b1) $display("FAIL b2b_gap_busy got %b want 1", b39); else passed++;
    frame(8'h0F, "b2b_0F", -1, 8'h00, b38, b39);
    total++; if (b38 !== 1'b1) $display("FAIL b2b_busy_last got %b want 1", b38); else passed++;
    total++; if (b39 !== 1'b0) $display("FAIL b2b_busy_drop got %b want 0", b39); else passed++;
  endtask

  // Third byte is pushed on the exact edge where the stop bit ends and the
  // queued second byte is popped.
  task automatic test_push_pop();
    logic b38, b39;
    wr(1'b0, DATA_A, 32'h0000_003C, 4'h1);
    wr(1'b0, DATA_A, 32'h0000_00C5, 4'h1);
    @(negedge clk);
    frame(8'h3C, "pp_3C", 38, 8'h96, b38, b39);
    frame(8'hC5, "pp_C5", -1, 8'h00, b38, b39);
    frame(8'h96, "pp_96", -1, 8'h00, b38, b39);
    total++; if (b38 !== 1'b1) $display("FAIL pp_busy_last got %b want 1", b38); else passed++;
    total++; if (b39 !== 1'b0) $display("FAIL pp_busy_drop got %b want 0", b39); else passed++;
  endtask

  // Reset during data bit 3 of 0xA5 (bit value 0) with 0x77 still queued.
  task automatic test_reset_mid_frame();
    logic [31:0] v;
    logic b38, b39;
    wr(1'b0, DATA_A, 32'h0000_00A5, 4'h1);
    wr(1'b0, DATA_A, 32'h0000_0077, 4'h1);
    repeat (18) @(negedge clk);
    total++; if (txd_s !== 1'b0) $display("FAIL mid_bit3_txd got %b want 0", txd_s); else passed++;
    rstn = 1'b0;
    @(negedge clk);
    total++; if (txd_s !== 1'b1) $display("FAIL mid_reset_txd got %b want 1", txd_s); else passed++;
    total++; if (busy_s !== 1'b0) $display("FAIL mid_reset_busy got %b want 0", busy_s); else passed++;
    rstn = 1'b1;
    rd(1'b0, STAT_A, v);
    total++; if (v !== 32'h6) $display("FAIL mid_reset_status got %h want 6", v); else passed++;
    wr(1'b0, DATA_A, 32'h0000_00E1, 4'h1);
    repeat (2) @(negedge clk);
    frame(8'hE1, "after_reset_E1", -1, 8'h00, b38, b39);
    total++; if (b39 !== 1'b0) $display("FAIL after_reset_busy got %b want 0", b39); else passed++;
  endtask

  initial begin
    bus_s.addr = 32'h0; bus_s.din = 32'h0; bus_s.write_enable = 4'h0;
    bus_b.addr = 32'h0; bus_b.din = 32'h0; bus_b.write_enable = 4'h0;
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_push_pop();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
